// File: rtl/data_bus_ctrl.sv
// data_bus_ctrl: data-side bus slave decoding a byte-enable RAM and a 16-bit LED register.
// Optional DBUS_ERR_CAPTURE_EN: adds err_addr capture and makes bus_err sticky until reset.
module data_bus_ctrl #(
   parameter int unsigned RAM_WORDS   = 1024,
   parameter logic [31:0] RAM_BASE    = 32'h0000_1000,
   parameter logic [31:0] LED_ADDR    = 32'h0000_2004,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic [15:0] leds,
`ifdef DBUS_ERR_CAPTURE_EN
   output logic [31:0] err_addr,
`endif
   output logic        bus_err
);

   localparam int unsigned IDX_W   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'(RAM_WORDS) * 33'd4);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, TURN} state_t;

   state_t           state;
   logic [3:0]       wait_cnt;
   logic [31:2]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [31:0]      ram [0:RAM_WORDS-1];

   logic [31:0]      word_addr;
   logic [31:0]      ram_off;
   logic [IDX_W-1:0] ram_idx;
   logic             ram_hit;
   logic             led_hit;
   logic             is_write;
   logic             do_access;
   logic             ram_we;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^mem_addr[1:0];

   always_comb begin
      word_addr = {addr_q, 2'b00};
      ram_off   = word_addr - RAM_BASE;
      ram_idx   = IDX_W'(ram_off >> 2);
      ram_hit   = ({1'b0, word_addr} >= {1'b0, RAM_BASE}) &&
                  ({1'b0, word_addr} < RAM_END) &&
                  (word_addr < 32'h0000_2000);
      led_hit   = (addr_q == LED_ADDR[31:2]);
      is_write  = (wstrb_q != 4'b0000);
      do_access = (state == ACCESS) && (wait_cnt == '0);
      ram_we    = do_access && ram_hit && is_write;
   end

   // Byte-enable RAM: no reset, so contents survive resetn.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         if (wstrb_q[0]) ram[ram_idx][7:0]   <= wdata_q[7:0];
         if (wstrb_q[1]) ram[ram_idx][15:8]  <= wdata_q[15:8];
         if (wstrb_q[2]) ram[ram_idx][23:16] <= wdata_q[23:16];
         if (wstrb_q[3]) ram[ram_idx][31:24] <= wdata_q[31:24];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         leds      <= '0;
         bus_err   <= 1'b0;
`ifdef DBUS_ERR_CAPTURE_EN
         err_addr  <= '0;
`endif
      end else begin
         mem_ready <= 1'b0;
`ifndef DBUS_ERR_CAPTURE_EN
         bus_err   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (mem_valid) begin
                  addr_q   <= mem_addr[31:2];
                  wdata_q  <= mem_wdata;
                  wstrb_q  <= mem_wstrb;
                  wait_cnt <= 4'(WAIT_STATES);
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
                  mem_rdata <= '0;
                  if (ram_hit) begin
                     if (!is_write) mem_rdata <= ram[ram_idx];
                  end else if (led_hit) begin
                     if (is_write) begin
                        if (wstrb_q[0]) leds[7:0]  <= wdata_q[7:0];
                        if (wstrb_q[1]) leds[15:8] <= wdata_q[15:8];
                     end else begin
                        mem_rdata <= {16'h0000, leds};
                     end
                  end else begin
                     bus_err <= 1'b1;
                     if (!is_write) mem_rdata <= 32'hDEAD_BEEF;
`ifdef DBUS_ERR_CAPTURE_EN
                     // bus_err is sticky here, so it doubles as "first fault already seen".
                     if (!bus_err) err_addr <= word_addr;
`endif
                  end
               end
            end
            RESP: begin
               mem_rdata <= '0;
               state     <= TURN;
            end
            TURN: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Randomized self-checking bench for data_bus_ctrl: one instance with WAIT_STATES=0, one with 3,
// both checked against a transaction-level model of the data map.
module tb_data_bus_ctrl;

   localparam logic [31:0] RAM_BASE  = 32'h0000_1000;
   localparam int unsigned RAM_WORDS = 1024;
   localparam logic [31:0] LED_A     = 32'h0000_2004;
   localparam int          WS0       = 0;
   localparam int          WS1       = 3;

   logic        clk = 1'b0;
   logic        resetn;
   logic [1:0]  valid;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [1:0]  ready;
   logic [1:0]  err;
   logic [31:0] rdata  [2];
   logic [15:0] leds_o [2];
`ifdef DBUS_ERR_CAPTURE_EN
   logic [31:0] err_addr_o [2];
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference state
   logic [31:0] ram_m  [2][RAM_WORDS];
   logic [15:0] led_m  [2];
   bit          errst_m[2];
   logic [31:0] erra_m [2];

   always #5 clk = ~clk;

   data_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .LED_ADDR(LED_A), .WAIT_STATES(WS0)) d0 (
      .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_addr(addr), .mem_wdata(wdata),
      .mem_wstrb(wstrb), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .leds(leds_o[0]),
`ifdef DBUS_ERR_CAPTURE_EN
      .err_addr(err_addr_o[0]),
`endif
      .bus_err(err[0]));

   data_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .LED_ADDR(LED_A), .WAIT_STATES(WS1)) d3 (
      .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_addr(addr), .mem_wdata(wdata),
      .mem_wstrb(wstrb), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .leds(leds_o[1]),
`ifdef DBUS_ERR_CAPTURE_EN
      .err_addr(err_addr_o[1]),
`endif
      .bus_err(err[1]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int ws(input int s);
      return (s == 0) ? WS0 : WS1;
   endfunction

   function automatic bit exp_err_idle(input int s);
`ifdef DBUS_ERR_CAPTURE_EN
      return errst_m[s];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         led_m[s]   = 16'h0000;
         errst_m[s] = 1'b0;
         erra_m[s]  = 32'h0;
      end
   endtask

   task automatic check_idle(input int s);
      chk("ready_idle", ready[s], 1'b0);
      chk("err_idle", err[s], exp_err_idle(s));
      chk("leds", {16'h0, leds_o[s]}, {16'h0, led_m[s]});
`ifdef DBUS_ERR_CAPTURE_EN
      chk("err_addr", err_addr_o[s], erra_m[s]);
`endif
   endtask

   // One bus transaction; caller is positioned 1ns after a rising edge.
   task automatic xfer(input int s, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input bit hold, output logic [31:0] rd);
      logic [31:0] wa;
      logic [31:0] exp_rd;
      bit          hit_ram, hit_led, unm, exp_err;
      int          idx, cyc;
      wa      = {a[31:2], 2'b00};
      hit_ram = (wa >= RAM_BASE) && (wa < 32'h2000) && ((wa - RAM_BASE) / 4 < RAM_WORDS);
      hit_led = (wa == LED_A);
      unm     = !hit_ram && !hit_led;
      idx     = hit_ram ? int'((wa - RAM_BASE) / 4) : 0;
      exp_rd  = 32'h0;
      if (st == 4'h0) begin
         if (hit_ram)      exp_rd = ram_m[s][idx];
         else if (hit_led) exp_rd = {16'h0, led_m[s]};
         else              exp_rd = 32'hDEAD_BEEF;
      end else if (hit_ram) begin
         for (int b = 0; b < 4; b++)
            if (st[b]) ram_m[s][idx][8*b +: 8] = d[8*b +: 8];
      end else if (hit_led) begin
         if (st[0]) led_m[s][7:0]  = d[7:0];
         if (st[1]) led_m[s][15:8] = d[15:8];
      end
      if (unm) begin
         if (!errst_m[s]) erra_m[s] = wa;
         errst_m[s] = 1'b1;
      end
`ifdef DBUS_ERR_CAPTURE_EN
      exp_err = errst_m[s];
`else
      exp_err = unm;
`endif

      addr = a; wdata = d; wstrb = st; valid[s] = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!ready[s] && cyc < 30);
      chk("latency", cyc, 2 + ws(s));
      rd = rdata[s];
      chk("rdata", rdata[s], exp_rd);
      chk("bus_err", err[s], exp_err);
      @(posedge clk); #1;
      if (!hold) valid[s] = 1'b0;
      chk("ready_width", ready[s], 1'b0);
      @(posedge clk); #1;
      valid[s] = 1'b0;
      if (hold) begin
         @(posedge clk); #1;
      end
      check_idle(s);
   endtask

   int          pool [8] = '{0, 1, 2, 3, 4, 5, 1022, 1023};
   logic [31:0] unm_list [6] = '{32'h0000_0040, 32'h0000_0FFC, 32'h0000_2000,
                                 32'h0000_2008, 32'h0000_3000, 32'hFFFF_1004};

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, a, d, pre;
      logic [3:0]  st;
      int          s;

      resetn = 1'b0; valid = 2'b00; addr = '0; wdata = '0; wstrb = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rdata", rdata[k], 32'h0);
         check_idle(k);
      end
      @(negedge clk); resetn = 1'b1;
      @(posedge clk); #1;

      for (int k = 0; k < 2; k++)
         foreach (pool[p]) xfer(k, RAM_BASE + 32'(4 * pool[p]), $urandom, 4'hF, 1'b0, rd);

      xfer(0, 32'h1000, 32'hA5A5_1234, 4'hF, 1'b0, rd);
      xfer(0, 32'h1000, 32'h0, 4'h0, 1'b0, rd);
      chk("tp_word", rd, 32'hA5A5_1234);
      xfer(0, 32'h1000, 32'hFFFF_FFFF, 4'b0100, 1'b0, rd);
      xfer(0, 32'h1000, 32'h0, 4'h0, 1'b0, rd);
      chk("tp_byte", rd, 32'hA5FF_1234);
      xfer(0, LED_A, 32'h1234_BEEF, 4'hF, 1'b0, rd);
      chk("tp_leds", {16'h0, leds_o[0]}, 32'h0000_BEEF);
      xfer(0, LED_A, 32'h0, 4'h0, 1'b0, rd);
      chk("tp_led_rd", rd, 32'h0000_BEEF);
      xfer(0, LED_A, 32'h0000_5500, 4'b0010, 1'b0, rd);
      chk("tp_leds2", {16'h0, leds_o[0]}, 32'h0000_55EF);
      xfer(0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, rd);
      chk("tp_unm_rd", rd, 32'hDEAD_BEEF);
      xfer(0, 32'h0000_3000, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
      xfer(0, 32'h1000, 32'h0, 4'h0, 1'b0, rd);
      xfer(0, 32'h1004, 32'hCAFE_0001, 4'hF, 1'b1, rd);
      xfer(1, 32'h1004, 32'hCAFE_0003, 4'hF, 1'b1, rd);
      xfer(1, LED_A, 32'h0000_BEEF, 4'h3, 1'b0, rd);

      // Reset while the WAIT_STATES=3 instance is still counting down in ACCESS.
      pre = ram_m[1][2];
      addr = 32'h1008; wdata = 32'h1111_1111; wstrb = 4'hF; valid[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) check_idle(k);
      valid[1] = 1'b0;
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      xfer(1, 32'h1008, 32'h0, 4'h0, 1'b0, rd);
      chk("rst_discard", rd, pre);

      for (int i = 0; i < 150; i++) begin
         s = $urandom_range(0, 1);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = RAM_BASE + 32'(4 * pool[$urandom_range(0, 7)]);
            6, 7:             a = LED_A;
            default:          a = unm_list[$urandom_range(0, 5)];
         endcase
         a  = a | 32'($urandom_range(0, 3));
         st = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         d  = $urandom;
         xfer(s, a, d, st, ($urandom_range(0, 3) == 0), rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
